// File: rtl/serial_lsb_comparator_if.sv
// Bit-serial comparator bus: operand bit pairs and control in, status and result out.
// master drives the operand stream, slave is the comparator.
interface serial_lsb_comparator_if;
  logic start;
  logic bit_valid;
  logic a_bit;
  logic b_bit;
  logic busy;
  logic done;
  logic eq;
  logic gt;
  logic lt;

  modport master (
    output start, bit_valid, a_bit, b_bit,
    input  busy, done, eq, gt, lt
  );

  modport slave (
    input  start, bit_valid, a_bit, b_bit,
    output busy, done, eq, gt, lt
  );
endinterface

// File: rtl/serial_lsb_comparator.sv
// LSB-first bit-serial magnitude comparator: one compare slice reused over WIDTH beats;
// a later (more significant) differing bit overrides any earlier verdict.
module serial_lsb_comparator #(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  serial_lsb_comparator_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          eq_reg, eq_next;
  logic          gt_reg, gt_next;
  logic          lt_reg, lt_next;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      eq_reg    <= 1'b0;
      gt_reg    <= 1'b0;
      lt_reg    <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      eq_reg    <= eq_next;
      gt_reg    <= gt_next;
      lt_reg    <= lt_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    eq_next    = eq_reg;
    gt_next    = gt_reg;
    lt_next    = lt_reg;

    case (state_reg)
      IDLE, DONE: begin
        // Results stay visible in IDLE until the next start clears them.
        if (bus.start) begin
          state_next = RUN;
          cnt_next   = '0;
          eq_next    = 1'b1;
          gt_next    = 1'b0;
          lt_next    = 1'b0;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (bus.bit_valid) begin
          cnt_next = cnt_reg + CW'(1);
          if (bus.a_bit != bus.b_bit) begin
            eq_next = 1'b0;
            gt_next = bus.b_bit;
            lt_next = bus.a_bit;
          end
          if (cnt_reg == LAST_IDX) begin
            state_next = DONE;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    busy_next = (state_next == RUN);
    done_next = (state_next == DONE);
  end

  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.eq   = eq_reg;
  assign bus.gt   = gt_reg;
  assign bus.lt   = lt_reg;

endmodule

// File: tb/tb_serial_lsb_comparator.sv
// Directed and exhaustive checks of the bit-serial comparator (WIDTH=4, plus a WIDTH=1 instance).
module tb_serial_lsb_comparator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  serial_lsb_comparator_if bus  ();
  serial_lsb_comparator_if bus1 ();

  serial_lsb_comparator #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  serial_lsb_comparator #(.WIDTH(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] res;  // {eq, gt(B>A), lt(B<A)}
  } vec_t;

  vec_t vecs[8];

  function automatic logic [4:0] st();
    return {bus.busy, bus.done, bus.eq, bus.gt, bus.lt};
  endfunction

  function automatic logic [4:0] st1();
    return {bus1.busy, bus1.done, bus1.eq, bus1.gt, bus1.lt};
  endfunction

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Apply inputs, let one rising edge pass, return 1 time unit after it.
  task automatic step(input logic s, input logic v, input logic a, input logic b);
    bus.start     = s;
    bus.bit_valid = v;
    bus.a_bit     = a;
    bus.b_bit     = b;
    @(posedge clk);
    #1;
  endtask

  // Start + 4 contiguous bits; returns in the DONE cycle.
  task automatic run_cmp(input string name, input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] res);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk({name, "_start"}, st(), 5'b10100);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, a[i], b[i]);
    chk({name, "_done"}, st(), {2'b01, res});
  endtask

  initial begin
    logic [3:0] ea;
    logic [3:0] eb;
    logic [2:0] er;
    int         bad;

    vecs[0] = '{4'b1010, 4'b1010, 3'b100};
    vecs[1] = '{4'b0111, 4'b1000, 3'b010};
    vecs[2] = '{4'b0011, 4'b0001, 3'b001};
    vecs[3] = '{4'b0000, 4'b0000, 3'b100};
    vecs[4] = '{4'b1111, 4'b0000, 3'b001};
    vecs[5] = '{4'b0000, 4'b1111, 3'b010};
    vecs[6] = '{4'b0001, 4'b1000, 3'b010};
    vecs[7] = '{4'b1000, 4'b0111, 3'b001};

    bus.start = 1'b0; bus.bit_valid = 1'b0; bus.a_bit = 1'b0; bus.b_bit = 1'b0;
    bus1.start = 1'b0; bus1.bit_valid = 1'b0; bus1.a_bit = 1'b0; bus1.b_bit = 1'b0;

    // Reset state
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_state", st(), 5'b00000);
    rst = 1'b0;

    // Reset mid-RUN after 2 bits discards the partial result
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("pre_rst_lt", st(), 5'b10001);
    rst = 1'b1;
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("midrun_rst", st(), 5'b00000);
    rst = 1'b0;
    run_cmp("post_rst", 4'b0011, 4'b0101, 3'b010);
    $display("[TB] reset mid-run then A=3 B=5 compare");

    // Table vectors: contiguous bits, then check results held in IDLE
    for (int i = 0; i < 8; i++) begin
      run_cmp($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].res);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("vec%0d_hold", i), st(), {2'b00, vecs[i].res});
      $display("[TB] vec %0d A=%b B=%b expect eq/gt/lt=%b", i, vecs[i].a, vecs[i].b, vecs[i].res);
    end

    // A=0111 B=1000: LSBs favour A (lt) until the MSB flips to gt
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("t3_bit0", st(), 5'b10001);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("t3_bit2", st(), 5'b10001);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    chk("t3_bit3", st(), 5'b01010);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    $display("[TB] A=0111 B=1000 override sequence");

    // A=0011 B=0001 with gaps 0,3,1 and a start pulse inside RUN
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    chk("t4_bit0", st(), 5'b10100);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("t4_bit1", st(), 5'b10001);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t4_start_ign", st(), 5'b10001);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("t4_bit2", st(), 5'b10001);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_gap", st(), 5'b10001);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("t4_done", st(), 5'b01001);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_hold", st(), 5'b00001);
    $display("[TB] A=0011 B=0001 with gaps and ignored start");

    // start together with bit_valid in IDLE: bit ignored
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("start_bit_idle", st(), 5'b10100);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("start_bit_done", st(), 5'b01100);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    $display("[TB] start with bit_valid in IDLE");

    // Back-to-back: second start issued in the DONE cycle of the first
    run_cmp("b2b_first", 4'd5, 4'd9, 3'b010);
    run_cmp("b2b_second", 4'd9, 4'd5, 3'b001);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("b2b_hold", st(), 5'b00001);
    $display("[TB] back-to-back A=5 B=9 then A=9 B=5");

    // Exhaustive WIDTH=4 against integer magnitude comparison
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        ea  = 4'(a);
        eb  = 4'(b);
        er  = {a == b, b > a, b < a};
        bad = 0;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
          if (bus.done !== 1'b0 || ($countones({bus.eq, bus.gt, bus.lt}) != 1)) bad++;
          step(1'b0, 1'b1, ea[i], eb[i]);
        end
        chk($sformatf("ex_%0d_%0d", a, b), st(), {2'b01, er});
        step(1'b0, 1'b0, 1'b0, 1'b0);
        if (bus.done !== 1'b0) bad++;
        chk($sformatf("ex_%0d_%0d_pulse", a, b), 5'(bad), 5'd0);
      end
    end
    $display("[TB] exhaustive 256 pairs applied");

    // WIDTH=1: one accepted bit then DONE
    bus1.start = 1'b1;
    @(posedge clk); #1;
    chk("w1_start", st1(), 5'b10100);
    bus1.start = 1'b0; bus1.bit_valid = 1'b1; bus1.a_bit = 1'b0; bus1.b_bit = 1'b1;
    @(posedge clk); #1;
    chk("w1_done", st1(), 5'b01010);
    bus1.bit_valid = 1'b0;
    @(posedge clk); #1;
    chk("w1_hold", st1(), 5'b00010);
    $display("[TB] WIDTH=1 A=0 B=1");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
